// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter, registered RF write stage and destination scoreboard.
// Define RF_WB_RR_EN for round-robin; otherwise fixed priority LD > ALU > HOST.
module rf_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic                   ld_valid,
  input  logic                   host_valid,
  output logic                   alu_ready,
  output logic                   ld_ready,
  output logic                   host_ready,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [ADDR_W-1:0]      ld_addr,
  input  logic [ADDR_W-1:0]      host_addr,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic [DATA_W-1:0]      ld_data,
  input  logic [DATA_W-1:0]      host_data,
  output logic                   rf_wena,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic                   claim_valid,
  input  logic [ADDR_W-1:0]      claim_addr,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic                   err_dup
);

  localparam int NREG = 1 << ADDR_W;

  // bit 0 = ALU, bit 1 = LD, bit 2 = HOST
  logic [2:0] req;
  logic [2:0] gnt;
  logic       xfer;

  assign req = {host_valid, ld_valid, alu_valid};

`ifdef RF_WB_RR_EN
  logic [1:0] ptr;
  logic [1:0] ptr_nxt;

  always_comb begin
    gnt = 3'b000;
    unique case (ptr)
      2'd1: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      2'd2: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

  always_comb begin
    ptr_nxt = ptr;
    unique case (1'b1)
      gnt[0]:  ptr_nxt = 2'd1;
      gnt[1]:  ptr_nxt = 2'd2;
      gnt[2]:  ptr_nxt = 2'd0;
      default: ptr_nxt = ptr;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= 2'd0;
    else      ptr <= ptr_nxt;
  end
`else
  always_comb begin
    gnt = 3'b000;
    if (req[1])      gnt = 3'b010;
    else if (req[0]) gnt = 3'b001;
    else if (req[2]) gnt = 3'b100;
  end
`endif

  // readies drop combinationally while reset is held
  assign alu_ready  = gnt[0] & rst;
  assign ld_ready   = gnt[1] & rst;
  assign host_ready = gnt[2] & rst;
  assign xfer       = |gnt;

  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_data;

  always_comb begin
    mux_addr = alu_addr;
    mux_data = alu_data;
    unique case (1'b1)
      gnt[1]: begin
        mux_addr = ld_addr;
        mux_data = ld_data;
      end
      gnt[2]: begin
        mux_addr = host_addr;
        mux_data = host_data;
      end
      default: begin
        mux_addr = alu_addr;
        mux_data = alu_data;
      end
    endcase
  end

  logic tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wena  <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      tag      <= 1'b0;
    end else begin
      rf_wena <= xfer;
      if (xfer) begin
        rf_waddr <= mux_addr;
        rf_wdata <= mux_data;
        tag      <= ~gnt[2];
      end
    end
  end

  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic            dup;

  assign set_vec = claim_valid ? (NREG'(1) << claim_addr) : '0;
  assign clr_vec = (rf_wena && tag) ? (NREG'(1) << rf_waddr) : '0;
  assign dup     = claim_valid && busy[claim_addr] && !clr_vec[claim_addr];

  // set after clear: a same-cycle claim belongs to a younger instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= '0;
      err_dup <= 1'b0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
      if (dup) err_dup <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: vector table plus reset/arbitration runs.
// Expectations follow RF_WB_RR_EN when the build defines it.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, host_valid;
  logic        alu_ready, ld_ready, host_ready;
  logic [2:0]  alu_addr, ld_addr, host_addr;
  logic [63:0] alu_data, ld_data, host_data;
  logic        rf_wena;
  logic [2:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        claim_valid;
  logic [2:0]  claim_addr;
  logic [7:0]  busy;
  logic        err_dup;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_W(64), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .ld_valid(ld_valid), .host_valid(host_valid),
    .alu_ready(alu_ready), .ld_ready(ld_ready), .host_ready(host_ready),
    .alu_addr(alu_addr), .ld_addr(ld_addr), .host_addr(host_addr),
    .alu_data(alu_data), .ld_data(ld_data), .host_data(host_data),
    .rf_wena(rf_wena), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .claim_valid(claim_valid), .claim_addr(claim_addr),
    .busy(busy), .err_dup(err_dup)
  );

  typedef struct {
    logic [2:0]  v;
    logic [2:0]  addr;
    logic [63:0] data;
    logic        cv;
    logic [2:0]  ca;
    logic [2:0]  er;
    logic        ew;
    logic [2:0]  ea;
    logic [63:0] ed;
    logic [7:0]  eb;
    logic        ee;
  } vec_t;

  vec_t tbl[23];

  localparam logic [63:0] D0 = 64'h1122334455667788;
  localparam logic [63:0] D1 = 64'hA5A5000000000001;
  localparam logic [63:0] D2 = 64'h5A5A00000000F00D;
  localparam logic [63:0] D3 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] D4 = 64'h0123456789ABCDEF;
  localparam logic [63:0] D5 = 64'hFFFFFFFFFFFFFFFF;

  function automatic vec_t mk(
    input logic [2:0] v, input logic [2:0] addr,
    input logic [63:0] data, input logic cv,
    input logic [2:0] ca, input logic [2:0] er,
    input logic ew, input logic [2:0] ea,
    input logic [63:0] ed, input logic [7:0] eb,
    input logic ee);
    vec_t r;
    r.v = v; r.addr = addr; r.data = data;
    r.cv = cv; r.ca = ca; r.er = er; r.ew = ew;
    r.ea = ea; r.ed = ed; r.eb = eb; r.ee = ee;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] rdy();
    return {host_ready, ld_ready, alu_ready};
  endfunction

  task automatic drive(input logic [2:0] v, input logic [2:0] a0,
                       input logic [2:0] a1, input logic [2:0] a2,
                       input logic [63:0] d0, input logic [63:0] d1,
                       input logic [63:0] d2);
    alu_valid = v[0]; ld_valid = v[1]; host_valid = v[2];
    alu_addr = a0; ld_addr = a1; host_addr = a2;
    alu_data = d0; ld_data = d1; host_data = d2;
  endtask

  logic [2:0] exp_g[6];
  logic [2:0] g_addr;

  initial begin
    rst = 1'b0;
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    claim_valid = 1'b0;
    claim_addr = 3'd0;

    tbl[0]  = mk(3'b000, 0, 0,  0, 0, 3'b000, 0, 0, 0,  8'h00, 0);
    tbl[1]  = mk(3'b001, 3, D0, 0, 0, 3'b001, 0, 0, 0,  8'h00, 0);
    tbl[2]  = mk(3'b000, 0, 0,  0, 0, 3'b000, 1, 3, D0, 8'h00, 0);
    tbl[3]  = mk(3'b000, 0, 0,  0, 0, 3'b000, 0, 3, D0, 8'h00, 0);
    tbl[4]  = mk(3'b000, 0, 0,  1, 5, 3'b000, 0, 3, D0, 8'h00, 0);
    tbl[5]  = mk(3'b000, 0, 0,  0, 0, 3'b000, 0, 3, D0, 8'h20, 0);
    tbl[6]  = mk(3'b100, 5, D2, 0, 0, 3'b100, 0, 3, D0, 8'h20, 0);
    tbl[7]  = mk(3'b010, 5, D1, 0, 0, 3'b010, 1, 5, D2, 8'h20, 0);
    tbl[8]  = mk(3'b000, 0, 0,  0, 0, 3'b000, 1, 5, D1, 8'h20, 0);
    tbl[9]  = mk(3'b000, 0, 0,  0, 0, 3'b000, 0, 5, D1, 8'h00, 0);
    tbl[10] = mk(3'b000, 0, 0,  1, 2, 3'b000, 0, 5, D1, 8'h00, 0);
    tbl[11] = mk(3'b001, 2, D3, 0, 0, 3'b001, 0, 5, D1, 8'h04, 0);
    tbl[12] = mk(3'b000, 0, 0,  1, 2, 3'b000, 1, 2, D3, 8'h04, 0);
    tbl[13] = mk(3'b000, 0, 0,  0, 0, 3'b000, 0, 2, D3, 8'h04, 0);
    tbl[14] = mk(3'b000, 0, 0,  1, 6, 3'b000, 0, 2, D3, 8'h04, 0);
    tbl[15] = mk(3'b000, 0, 0,  1, 6, 3'b000, 0, 2, D3, 8'h44, 0);
    tbl[16] = mk(3'b000, 0, 0,  0, 0, 3'b000, 0, 2, D3, 8'h44, 1);
    tbl[17] = mk(3'b001, 6, D4, 0, 0, 3'b001, 0, 2, D3, 8'h44, 1);
    tbl[18] = mk(3'b000, 0, 0,  0, 0, 3'b000, 1, 6, D4, 8'h44, 1);
    tbl[19] = mk(3'b000, 0, 0,  0, 0, 3'b000, 0, 6, D4, 8'h04, 1);
    tbl[20] = mk(3'b010, 0, D5, 0, 0, 3'b010, 0, 6, D4, 8'h04, 1);
    tbl[21] = mk(3'b000, 0, 0,  0, 0, 3'b000, 1, 0, D5, 8'h04, 1);
    tbl[22] = mk(3'b000, 0, 0,  0, 0, 3'b000, 0, 0, D5, 8'h04, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].v, tbl[i].addr, tbl[i].addr, tbl[i].addr,
            tbl[i].data, tbl[i].data, tbl[i].data);
      claim_valid = tbl[i].cv;
      claim_addr = tbl[i].ca;
      #3;
      chk($sformatf("v%0d ready", i), 64'(rdy()), 64'(tbl[i].er));
      chk($sformatf("v%0d wena", i), 64'(rf_wena), 64'(tbl[i].ew));
      chk($sformatf("v%0d waddr", i), 64'(rf_waddr), 64'(tbl[i].ea));
      chk($sformatf("v%0d wdata", i), rf_wdata, tbl[i].ed);
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].eb));
      chk($sformatf("v%0d err", i), 64'(err_dup), 64'(tbl[i].ee));
    end

    // mid-transfer reset with busy = 0x24
    @(posedge clk); #1;
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    claim_valid = 1'b1; claim_addr = 3'd5;
    @(posedge clk); #1;
    claim_valid = 1'b0;
    drive(3'b100, 0, 0, 3'd1, 0, 0, 64'h77);
    #3;
    chk("rs host ready", 64'(rdy()), 64'(3'b100));
    chk("rs busy pre", 64'(busy), 64'h24);
    @(posedge clk); #1;
    drive(3'b111, 3'd1, 3'd2, 3'd4, 64'hA1, 64'hB2, 64'hC4);
    #2;
    chk("rs wena pre", 64'(rf_wena), 64'd1);
    chk("rs busy inflight", 64'(busy), 64'h24);
    chk("rs err pre", 64'(err_dup), 64'd1);
    rst = 1'b0;
    #1;
    chk("rs wena", 64'(rf_wena), 64'd0);
    chk("rs waddr", 64'(rf_waddr), 64'd0);
    chk("rs wdata", rf_wdata, 64'd0);
    chk("rs busy", 64'(busy), 64'd0);
    chk("rs err", 64'(err_dup), 64'd0);
    chk("rs ready", 64'(rdy()), 64'd0);
    @(posedge clk); #2;
    chk("rs ready held", 64'(rdy()), 64'd0);
    chk("rs wena held", 64'(rf_wena), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;

`ifdef RF_WB_RR_EN
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    exp_g = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
`endif
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk); #2;
        g_addr = exp_g[k-1][0] ? 3'd1 : exp_g[k-1][1] ? 3'd2 : 3'd4;
        chk($sformatf("arb%0d wena", k), 64'(rf_wena), 64'd1);
        chk($sformatf("arb%0d waddr", k), 64'(rf_waddr), 64'(g_addr));
      end
      chk($sformatf("arb%0d grant", k), 64'(rdy()), 64'(exp_g[k]));
    end

    @(posedge clk); #1;
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("tail wena", 64'(rf_wena), 64'd0);
    chk("tail busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
